// File: rtl/scarf_regmap.sv
// scarf_regmap: byte-wide register-map slave on the SCARF bus.
// The first byte of a transaction addressed to SLAVE_ID is the register address.
// Each following byte is either written to that address or, for a read, acts as
// a dummy byte. Either way the address then post-increments and wraps at 8'hFF.
// R/W configuration registers occupy 0..NUM_RW-1. Read-only status bytes follow
// at NUM_RW..NUM_RW+NUM_RO-1. All other addresses read as 8'h00, and writes to
// them are dropped.
module scarf_regmap #(
  parameter logic [6:0]          SLAVE_ID = 7'h02,
  parameter int                  NUM_RW   = 16,
  parameter int                  NUM_RO   = 8,
  parameter logic [8*NUM_RW-1:0] RW_RESET = '0
) (
  input  logic                                     clk,
  input  logic                                     rst_n_sync,
  input  logic [7:0]                               data_in,
  input  logic                                     data_in_valid,
  input  logic                                     data_in_finished,
  input  logic [6:0]                               slave_id,
  input  logic                                     rnw,
  output logic [7:0]                               read_data_out,
  // Kept at least one byte wide so that a build with NUM_RO=0 still elaborates.
  input  logic [8*((NUM_RO > 0) ? NUM_RO : 1)-1:0] status_in,
  output logic [8*NUM_RW-1:0]                      cfg_out,
  output logic [NUM_RW-1:0]                        cfg_wr_pulse
);

  localparam int RO_W = (NUM_RO > 0) ? NUM_RO : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    IGNORE = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_addr;
  logic [7:0]          r_rdata;
  logic [8*NUM_RW-1:0] r_cfg;
  logic [NUM_RW-1:0]   r_wr_pulse;

  state_t              w_state_next;
  logic [7:0]          w_addr_next;
  logic                w_wr_en;
  logic                w_rd_active;
  logic [NUM_RW-1:0]   w_wr_sel;

  // Map an address onto a cfg register, a status byte, or zero.
  function automatic logic [7:0] f_read_decode(
    input logic [7:0]          a,
    input logic [8*NUM_RW-1:0] cfg,
    input logic [8*RO_W-1:0]   st
  );
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_RW; i++) begin
      if ({1'b0, a} == 9'(i)) v = cfg[8*i +: 8];
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if ({1'b0, a} == 9'(NUM_RW + i)) v = st[8*i +: 8];
    end
    return v;
  endfunction

  // Next state and next address. A finish strobe always wins over the state
  // transition, but any byte strobed in the same cycle is still consumed.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    unique case (r_state)
      IDLE: begin
        if (data_in_valid) begin
          if (slave_id == SLAVE_ID) begin
            w_addr_next  = data_in;
            w_state_next = DATA;
          end else begin
            w_state_next = IGNORE;
          end
        end
      end
      DATA: begin
        if (data_in_valid) w_addr_next = r_addr + 8'd1;
      end
      IGNORE: begin
        w_state_next = IGNORE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (data_in_finished) w_state_next = IDLE;
  end

  // Write enable and one-hot register select. Out-of-range addresses match no
  // register, so nothing is written and no strobe fires.
  always_comb begin
    w_wr_en  = (r_state == DATA) && data_in_valid && !rnw;
    w_wr_sel = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      w_wr_sel[i] = w_wr_en && (r_addr == 8'(i));
    end
  end

  // Read data is computed from the next address. It therefore reflects
  // reg[addr] immediately after the strobe that set or advanced addr.
  assign w_rd_active = (w_state_next == DATA) && rnw;

  // Control FSM with registered read data. Read data is forced to zero outside
  // a read so it can be OR-combined with other slaves.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state <= IDLE;
      r_addr  <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_rdata <= w_rd_active ? f_read_decode(w_addr_next, r_cfg, status_in) : 8'h00;
    end
  end

  // Configuration register file and its one-cycle write strobes.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_cfg      <= RW_RESET;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_sel;
      for (int i = 0; i < NUM_RW; i++) begin
        if (w_wr_sel[i]) r_cfg[8*i +: 8] <= data_in;
      end
    end
  end

  assign read_data_out = r_rdata;
  assign cfg_out       = r_cfg;
  assign cfg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_scarf_regmap.sv
// Directed testbench for scarf_regmap (SLAVE_ID=2, 16 R/W, 8 RO, reg3 resets to 5A).
module tb_scarf_regmap;

  localparam logic [127:0] RST = 128'h5A00_0000;

  logic         clk;
  logic         rst_n_sync;
  logic [7:0]   data_in;
  logic         data_in_valid;
  logic         data_in_finished;
  logic [6:0]   slave_id;
  logic         rnw;
  logic [7:0]   read_data_out;
  logic [63:0]  status_in;
  logic [127:0] cfg_out;
  logic [15:0]  cfg_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_cfg;

  scarf_regmap #(
    .SLAVE_ID (7'h02),
    .NUM_RW   (16),
    .NUM_RO   (8),
    .RW_RESET (RST)
  ) dut (
    .clk              (clk),
    .rst_n_sync       (rst_n_sync),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_finished (data_in_finished),
    .slave_id         (slave_id),
    .rnw              (rnw),
    .read_data_out    (read_data_out),
    .status_in        (status_in),
    .cfg_out          (cfg_out),
    .cfg_wr_pulse     (cfg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One strobed byte; on return the edge that consumed it has passed.
  task automatic send(input logic [6:0] id, input logic r, input logic [7:0] d, input logic fin);
    slave_id         = id;
    rnw              = r;
    data_in          = d;
    data_in_valid    = 1'b1;
    data_in_finished = fin;
    cyc();
    data_in_valid    = 1'b0;
    data_in_finished = 1'b0;
  endtask

  task automatic fin_txn();
    data_in_finished = 1'b1;
    cyc();
    data_in_finished = 1'b0;
  endtask

  initial begin
    rst_n_sync       = 1'b0;
    data_in          = 8'h00;
    data_in_valid    = 1'b0;
    data_in_finished = 1'b0;
    slave_id         = 7'h00;
    rnw              = 1'b0;
    status_in        = {8'hE7, 40'h0, 8'h31, 8'h77};
    exp_cfg          = RST;

    // Reset hold
    repeat (3) cyc();
    chk("rst_cfg", cfg_out, RST);
    chk("rst_rdata", read_data_out, 8'h00);
    chk("rst_pulse", cfg_wr_pulse, 16'h0);
    rst_n_sync = 1'b1;
    cyc();
    // First byte after reset must be taken as an address: read reg3
    send(7'h02, 1'b1, 8'h03, 1'b0);
    chk("idle_after_rst_rd3", read_data_out, 8'h5A);
    send(7'h02, 1'b1, 8'h00, 1'b0);
    chk("rd4", read_data_out, 8'h00);
    fin_txn();
    chk("rdata_idle", read_data_out, 8'h00);

    // Burst write 0E: AA BB CC
    send(7'h02, 1'b0, 8'h0E, 1'b0);
    chk("bw_addr_pulse", cfg_wr_pulse, 16'h0);
    send(7'h02, 1'b0, 8'hAA, 1'b0);
    exp_cfg[8*14 +: 8] = 8'hAA;
    chk("bw_reg14", cfg_out, exp_cfg);
    chk("bw_pulse14", cfg_wr_pulse, 16'h4000);
    send(7'h02, 1'b0, 8'hBB, 1'b0);
    exp_cfg[8*15 +: 8] = 8'hBB;
    chk("bw_reg15", cfg_out, exp_cfg);
    chk("bw_pulse15", cfg_wr_pulse, 16'h8000);
    send(7'h02, 1'b0, 8'hCC, 1'b0);
    chk("bw_ro_nowrite", cfg_out, exp_cfg);
    chk("bw_ro_nopulse", cfg_wr_pulse, 16'h0);
    chk("bw_wr_rdata", read_data_out, 8'h00);
    fin_txn();
    chk("bw_end_pulse", cfg_wr_pulse, 16'h0);

    // Burst read across R/W -> RO
    send(7'h02, 1'b1, 8'h0F, 1'b0);
    chk("br_reg15", read_data_out, 8'hBB);
    send(7'h02, 1'b1, 8'h00, 1'b0);
    chk("br_st0", read_data_out, 8'h77);
    send(7'h02, 1'b1, 8'h00, 1'b0);
    chk("br_st1", read_data_out, 8'h31);
    send(7'h02, 1'b1, 8'h00, 1'b0);
    chk("br_st2", read_data_out, 8'h00);
    fin_txn();
    chk("br_end", read_data_out, 8'h00);

    // Last RO byte and the first unmapped address
    send(7'h02, 1'b1, 8'h17, 1'b0);
    chk("rd_st7", read_data_out, 8'hE7);
    send(7'h02, 1'b1, 8'h00, 1'b0);
    chk("rd_unmapped18", read_data_out, 8'h00);
    fin_txn();

    // Wrong ID
    send(7'h01, 1'b0, 8'h00, 1'b0);
    send(7'h01, 1'b0, 8'hFF, 1'b0);
    chk("wid_cfg", cfg_out, exp_cfg);
    chk("wid_pulse", cfg_wr_pulse, 16'h0);
    chk("wid_rdata", read_data_out, 8'h00);
    send(7'h01, 1'b1, 8'h03, 1'b0);
    chk("wid_rd_rdata", read_data_out, 8'h00);
    fin_txn();
    send(7'h02, 1'b0, 8'h01, 1'b0);
    send(7'h02, 1'b0, 8'h9C, 1'b0);
    exp_cfg[8*1 +: 8] = 8'h9C;
    chk("after_wid_reg1", cfg_out, exp_cfg);
    chk("after_wid_pulse1", cfg_wr_pulse, 16'h0002);
    fin_txn();

    // Address wrap FF -> 00
    send(7'h02, 1'b0, 8'hFF, 1'b0);
    send(7'h02, 1'b0, 8'h11, 1'b0);
    chk("wrap_ff_drop", cfg_out, exp_cfg);
    chk("wrap_ff_nopulse", cfg_wr_pulse, 16'h0);
    send(7'h02, 1'b0, 8'h22, 1'b0);
    exp_cfg[7:0] = 8'h22;
    chk("wrap_reg0", cfg_out, exp_cfg);
    chk("wrap_pulse0", cfg_wr_pulse, 16'h0001);
    fin_txn();
    send(7'h02, 1'b1, 8'h80, 1'b0);
    chk("rd_80", read_data_out, 8'h00);
    fin_txn();

    // Valid + finished on the last write byte
    send(7'h02, 1'b0, 8'h05, 1'b0);
    send(7'h02, 1'b0, 8'h66, 1'b1);
    exp_cfg[8*5 +: 8] = 8'h66;
    chk("simul_reg5", cfg_out, exp_cfg);
    chk("simul_pulse5", cfg_wr_pulse, 16'h0020);
    // Back in IDLE: this byte is an address, reading reg3
    send(7'h02, 1'b1, 8'h03, 1'b0);
    chk("simul_idle_rd3", read_data_out, 8'h5A);
    chk("simul_no_extra_wr", cfg_out, exp_cfg);
    fin_txn();

    // Reset between address and data bytes
    send(7'h02, 1'b0, 8'h07, 1'b0);
    rst_n_sync = 1'b0;
    #2;
    chk("abort_cfg_async", cfg_out, RST);
    cyc();
    rst_n_sync = 1'b1;
    cyc();
    chk("abort_pulse", cfg_wr_pulse, 16'h0);
    send(7'h02, 1'b0, 8'h99, 1'b0);
    chk("abort_no_write", cfg_out, RST);
    chk("abort_no_pulse", cfg_wr_pulse, 16'h0);
    fin_txn();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scarf_regmap.md
Name: scarf_regmap

Overview:
- Byte-wide register-map slave on the SCARF bus. It sits directly downstream of uart_scarf, in parallel with scarf_bram, and shares uart_scarf's data_out/data_out_valid/data_out_finished/slave_id/rnw outputs.
- Provides NUM_RW read/write configuration registers, driven to fabric with per-register write strobes.
- Provides NUM_RO read-only status registers sampled from fabric.
- Supports auto-incrementing burst reads and writes.

Parameters:
- SLAVE_ID, 7'h02: bus ID this slave responds to.
- NUM_RW, 16: number of 8-bit R/W registers at addresses 0..NUM_RW-1 (1..128).
- NUM_RO, 8: number of 8-bit read-only registers at addresses NUM_RW..NUM_RW+NUM_RO-1 (0..128). NUM_RW+NUM_RO <= 256.
- RW_RESET, {NUM_RW{8'h00}}: flat reset value of the R/W registers; register i = bits [8i+7:8i].

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n_sync, input, 1: reset, asynchronous, active-low, used directly in every flop's async clear.
- data_in, input, 8: byte from uart_scarf.
- data_in_valid, input, 1: one-cycle strobe; data_in is valid.
- data_in_finished, input, 1: one-cycle strobe; transaction ended.
- slave_id, input, 7: target of the current transaction; stable whenever data_in_valid=1.
- rnw, input, 1: 1 = read, 0 = write; stable whenever data_in_valid=1.
- read_data_out, output, 8: read byte returned to uart_scarf.
- status_in, input, 8*NUM_RO: read-only register values, flat.
- cfg_out, output, 8*NUM_RW: R/W register contents, flat.
- cfg_wr_pulse, output, NUM_RW: one-cycle strobe for register i, asserted in the cycle after it is written.

Behaviour:
- Reset values:
  - State = IDLE; addr = 0; read_data_out = 8'h00; cfg_out = RW_RESET; cfg_wr_pulse = 0.
  - Reset asserted mid-transaction aborts the transaction immediately with no partial write.
- Transaction framing:
  - uart_scarf consumes the ID/command byte itself.
  - The first data_in_valid of a transaction carries the register address.
  - Subsequent data_in_valid strobes are data bytes (write) or dummy bytes (read).
- FSM states: IDLE, DATA, IGNORE.
  - IDLE, data_in_valid with slave_id==SLAVE_ID: latch addr <= data_in, go to DATA.
  - IDLE, data_in_valid with slave_id!=SLAVE_ID: go to IGNORE.
  - DATA, write (rnw=0), data_in_valid: if addr < NUM_RW, reg[addr] <= data_in and cfg_wr_pulse[addr]=1 on the next cycle. Otherwise the byte is discarded silently. Then addr <= addr+1.
  - DATA, read (rnw=1), data_in_valid: addr <= addr+1.
  - Any state, data_in_finished: go to IDLE.
  - If data_in_valid and data_in_finished are asserted in the same cycle, the byte is processed first, then the FSM goes to IDLE.
- Address arithmetic:
  - addr is 8 bits and wraps 8'hFF -> 8'h00.
  - No range check beyond the decode below.
- Read data:
  - read_data_out is registered. It is updated every cycle from addr while in DATA with rnw=1.
  - It therefore shows reg[addr] one cycle after the address byte, and one cycle after each dummy byte (post-increment).
  - Decode: addr < NUM_RW gives cfg register; NUM_RW <= addr < NUM_RW+NUM_RO gives status_in byte (addr-NUM_RW); otherwise 8'h00.
  - read_data_out = 8'h00 in IDLE and IGNORE, so it can be OR-combined with other slaves.
- status_in is sampled only at the read register update; it is not otherwise synchronized (fabric supplies clk-domain data).
- Write and read in the same transaction do not occur; rnw is taken per strobe.
- cfg_wr_pulse:
  - At most one bit is high per cycle.
  - Never asserted for out-of-range or IGNORE writes.
- cfg_out changes exactly one cycle after the data_in_valid that writes it.

Test Plan:
- Reset: hold rst_n_sync=0 with RW_RESET reg3=8'h5A -> cfg_out reg3=8'h5A, read_data_out=0, cfg_wr_pulse=0. Release and check that state is IDLE.
- Burst write: ID 02, rnw=0, bytes 8'h0E,8'hAA,8'hBB,8'hCC, then finished -> reg14=AA and reg15=BB. Address 16 (RO) is not written. cfg_wr_pulse bit14 then bit15 each pulse for one cycle; no other pulses.
- Burst read across regions: status_in byte0=8'h77; ID 02, rnw=1, address 8'h0F, 3 dummies -> read_data_out sequence reg15, 8'h77 (addr 16), status byte1. Each value appears one cycle after its strobe.
- Wrong ID: ID 01 write address 0, data 8'hFF -> no cfg_out change, no pulse, read_data_out stays 0. The next ID-02 transaction works normally.
- Wrap and unmapped: write address 8'hFF, data 8'h11, 8'h22 -> 8'hFF discarded, addr wraps, reg0=8'h22. A read at 8'h80 returns 8'h00.
- Simultaneous and abort:
  - data_in_valid+data_in_finished on the last write byte: byte is written, FSM returns to IDLE.
  - Reset asserted between the address and data bytes: no write, cfg_out returns to RW_RESET.
